// File: rtl/spi_cmd_arbiter_if.sv
// Bundle of requester-side handshakes and spi_master-side command signals for
// spi_cmd_arbiter. The arbiter uses the master view, the environment the slave view.
interface spi_cmd_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned MOSI_W  = 24,
  parameter int unsigned MISO_W  = 9
);
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ-1:0]        req_rd;
  logic [NUM_REQ*MOSI_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        req_done;
  logic [MISO_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      sm_wr_cmd;
  logic                      sm_rd_cmd;
  logic [MOSI_W-1:0]         sm_wr_data;
  logic [MISO_W-1:0]         sm_rd_data;
  logic                      sm_busy;
  logic                      sm_ncs;
  logic [NUM_REQ-1:0]        dev_cs_n;
  logic                      arb_busy;

  modport master (
    input  req_wr, req_rd, req_data, sm_rd_data, sm_busy, sm_ncs,
    output req_ack, req_done, rsp_data, rsp_err, sm_wr_cmd, sm_rd_cmd, sm_wr_data,
           dev_cs_n, arb_busy
  );

  modport slave (
    output req_wr, req_rd, req_data, sm_rd_data, sm_busy, sm_ncs,
    input  req_ack, req_done, rsp_data, rsp_err, sm_wr_cmd, sm_rd_cmd, sm_wr_data,
           dev_cs_n, arb_busy
  );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter that serialises configuration requesters onto one spi_master
// and routes that master's chip select to the granted device.
module spi_cmd_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned MOSI_W   = 24,
  parameter int unsigned MISO_W   = 9,
  parameter int unsigned START_TO = 255
) (
  input  logic              clk_20m,
  input  logic              rstn,
  spi_cmd_arbiter_if.master bus_io
);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(START_TO + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(START_TO - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StWaitEnd,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic              op_rd_q, op_rd_d;
  logic [MOSI_W-1:0] data_q, data_d;
  logic [MISO_W-1:0] rsp_q, rsp_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] req_any;
  logic               found;
  logic [IdxW-1:0]    pick;
  int unsigned        idx;

  // Round-robin search starting at ptr_q, wrapping without a modulo operator.
  always_comb begin
    req_any = bus_io.req_wr | bus_io.req_rd;
    found   = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = off + 32'(ptr_q);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_any[IdxW'(idx)]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    op_rd_d = op_rd_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          // A write wins when both are raised; the read stays pending.
          op_rd_d = ~bus_io.req_wr[pick];
          data_d  = bus_io.req_data[MOSI_W*pick +: MOSI_W];
          err_d   = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        if (bus_io.sm_busy) begin
          state_d = StWaitEnd;
        end else if (cnt_q >= CntLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitEnd: begin
        if (!bus_io.sm_busy) begin
          if (op_rd_q) rsp_d = bus_io.sm_rd_data;
          state_d = StDone;
        end
      end
      StDone: begin
        ptr_d   = (grant_q == IdxLast) ? '0 : grant_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_20m) begin
    if (!rstn) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      op_rd_q <= 1'b0;
      data_q  <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      op_rd_q <= op_rd_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Chip-select routing depends only on registered state so a new grant cannot glitch it.
  always_comb begin
    bus_io.sm_wr_cmd  = (state_q == StIssue) && !op_rd_q;
    bus_io.sm_rd_cmd  = (state_q == StIssue) && op_rd_q;
    bus_io.sm_wr_data = data_q;
    bus_io.rsp_data   = rsp_q;
    bus_io.rsp_err    = err_q;
    bus_io.arb_busy   = (state_q != StIdle);
    bus_io.req_ack    = '0;
    bus_io.req_done   = '0;
    bus_io.dev_cs_n   = '1;
    if (state_q == StIssue) bus_io.req_ack[grant_q] = 1'b1;
    if (state_q == StDone) bus_io.req_done[grant_q] = 1'b1;
    if (state_q != StIdle) bus_io.dev_cs_n[grant_q] = bus_io.sm_ncs;
  end
endmodule

// File: doc/spi_cmd_arbiter.md
SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning the number of configuration requesters (legal range 2..4).
REQ-002 SHALL have parameter MOSI_W, default 24, meaning the SPI write word width (16-bit instruction header plus 8-bit data).
REQ-003 SHALL have parameter MISO_W, default 9, meaning the SPI read word width.
REQ-004 SHALL have parameter START_TO, default 255, meaning the maximum cycles from command issue to sm_busy rising.
REQ-005 SHALL have port: clk_20m  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port: rstn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port: req_wr  in  NUM_REQ  per-requester write request, level, held until req_ack.
REQ-008 SHALL have port: req_rd  in  NUM_REQ  per-requester read request, level, held until req_ack.
REQ-009 SHALL have port: req_data  in  NUM_REQ*MOSI_W  per-requester word; slice i holds requester i.
REQ-010 SHALL have port: req_ack  out  NUM_REQ  one-cycle pulse when the request is accepted.
REQ-011 SHALL have port: req_done  out  NUM_REQ  one-cycle pulse when the transfer ends.
REQ-012 SHALL have port: rsp_data  out  MISO_W  read data; valid with req_done.
REQ-013 SHALL have port: rsp_err  out  1  timeout flag; valid with req_done.
REQ-014 SHALL have port: sm_wr_cmd / sm_rd_cmd  out  1 each  command pulses to spi_master.
REQ-015 SHALL have port: sm_wr_data  out  MOSI_W  word to spi_master.
REQ-016 SHALL have port: sm_rd_data  in  MISO_W  read data from spi_master.
REQ-017 SHALL have port: sm_busy  in  1  spi_master busy.
REQ-018 SHALL have port: sm_ncs  in  1  chip select from spi_master.
REQ-019 SHALL have port: dev_cs_n  out  NUM_REQ  per-device chip select; index i serves requester i (0 = AD9517, 1 = ADC0).
REQ-020 SHALL have port: arb_busy  out  1  high whenever the state is not IDLE.

Function
REQ-021 SHALL implement the FSM IDLE -> ISSUE -> WAIT_START -> WAIT_END -> DONE -> IDLE.
REQ-022 In IDLE, if any req_wr|req_rd bit is set, the FSM SHALL grant one requester by round-robin.
- The search starts at pointer ptr; ptr is 0 after reset.
- On grant: latch the grant index, req_data slice and operation type; go to ISSUE on the same edge.
REQ-023 In ISSUE (exactly 1 cycle): sm_wr_cmd or sm_rd_cmd = 1 and req_ack[grant] = 1; sm_wr_data holds the latched word.
REQ-024 Total latency from the edge that samples the request to sm_*_cmd high SHALL be 1 cycle.
REQ-025 If req_wr and req_rd are both set for the granted requester, the operation SHALL be a write; the read request stays pending.
REQ-026 In WAIT_START: on sm_busy = 1 go to WAIT_END; after START_TO cycles without sm_busy, set the error flag and go to DONE.
REQ-027 In WAIT_END: on sm_busy = 0 go to DONE; no timeout.
REQ-028 In DONE (1 cycle): req_done[grant] = 1.
- rsp_data = sm_rd_data captured at WAIT_END exit for reads; unchanged for writes.
- rsp_err = error flag.
- ptr = (grant+1) mod NUM_REQ.
REQ-029 In states ISSUE..DONE, dev_cs_n[grant] SHALL equal sm_ncs; all other bits = 1.
REQ-030 In IDLE, dev_cs_n SHALL be all ones regardless of sm_ncs.
REQ-031 dev_cs_n routing SHALL use only the registered grant and state, so it is glitch-free on grant change.
REQ-032 A requester's deassertion after req_ack SHALL NOT abort the transfer.
REQ-033 New requests arriving in non-IDLE states SHALL wait; no request is lost if held.
REQ-034 The timeout counter SHALL be wide enough for START_TO, clear on ISSUE, and saturate (never wrap).

Reset
REQ-035 On rstn = 0 at a clock edge, the following SHALL apply:
- state = IDLE, ptr = 0, grant = 0;
- sm_wr_cmd = sm_rd_cmd = 0, sm_wr_data = 0;
- req_ack = req_done = 0, rsp_data = 0, rsp_err = 0;
- dev_cs_n = all ones, arb_busy = 0.
REQ-036 Reset mid-transfer SHALL abandon the transfer with no req_done pulse; dev_cs_n goes all ones on the next cycle.

Verification
REQ-037 Single write: req_wr[0] = 1, req_data[23:0] = 0x000190; bench master raises busy 3 cycles after the command and holds it 40 cycles.
- Required: sm_wr_cmd one cycle after the request, sm_wr_data = 0x000190, req_ack[0] once.
- Required: dev_cs_n[0] follows sm_ncs, dev_cs_n[1] = 1 throughout, req_done[0] one cycle after busy falls, rsp_err = 0.
REQ-038 Read: req_rd[1] = 1, word 0x800100; model returns sm_rd_data = 0x0A5 -> sm_rd_cmd pulse, req_done[1] with rsp_data = 0x0A5.
REQ-039 Contention: req_wr = 2'b11 held continuously.
- Required: grants in the order 0, 1, 0, 1.
- Required: no overlap of dev_cs_n lows; arb_busy high between consecutive grants except the 1-cycle IDLE.
REQ-040 Timeout: sm_busy tied 0 and req_wr[0] = 1 -> req_done[0] with rsp_err = 1 exactly START_TO cycles after WAIT_START entry, then IDLE.
REQ-041 Reset mid-operation: rstn = 0 during WAIT_END -> next cycle: all outputs at reset values, no req_done; a new request after reset is granted to requester 0.
REQ-042 Simultaneous wr+rd: req_wr[0] = req_rd[0] = 1 -> a write is issued first.
